code_cmp_sequencer: RTL and testbench

Controller that shares one combinational multi-code converter/comparator instance (multi_code_system) across a stream of operand-pair requests. Per accepted request it steps through the enabled code modes in ascending order: Binary 00, Gray 01, Excess-3 10, BCD 11. For each mode it drives the instance, waits a settle interval, captures convA/convB/gt/lt/eq and presents one result beat per mode on a valid/ready output.

---
 rtl/code_cmp_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_code_cmp_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_cmp_sequencer.sv
// code_cmp_sequencer
//
// Time-shares one combinational converter/comparator (multi_code_system)
// across a stream of operand-pair requests. For each accepted request the
// enabled code modes are visited in ascending order (0 Binary, 1 Gray,
// 2 Excess-3, 3 BCD). For each mode the converter is driven and allowed to
// settle, its outputs are captured, and one result beat is presented.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The request side accepts only in IDLE (req_ready is high only
// in IDLE). On the result side res_* are held stable while res_valid is high
// and res_ready is low.
//
// Optional build macro: CMP_CHECK_EN adds a sticky err flag that is set when
// the captured {gt,lt,eq} is not one-hot. Without the macro err is tied to 0.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_a, req_b, req_mask   operands and mode-enable mask (0000 acts as 0001)
//   cc_a, cc_b, cc_mode      drive to the converter/comparator
//   cc_gt/lt/eq, cc_conva/b  converter/comparator results
//   res_valid/res_ready      result beat handshake
//   res_mode, res_conva/b    captured mode and conversions
//   res_flags, res_last      captured {gt,lt,eq}, last beat of the request
//   busy                     controller not idle
//   err                      sticky comparator-consistency error
module code_cmp_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_mask,
    output logic [WIDTH-1:0] cc_a,
    output logic [WIDTH-1:0] cc_b,
    output logic [1:0]       cc_mode,
    input  logic             cc_gt,
    input  logic             cc_lt,
    input  logic             cc_eq,
    input  logic [WIDTH-1:0] cc_conva,
    input  logic [WIDTH-1:0] cc_convb,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_mode,
    output logic [WIDTH-1:0] res_conva,
    output logic [WIDTH-1:0] res_convb,
    output logic [2:0]       res_flags,
    output logic             res_last,
    output logic             busy,
    output logic             err
);

    // A settle interval of 0 would leave no time between drive and capture.
    localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int CNT_W      = $clog2(SETTLE_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cc_a_q, cc_a_d;
    logic [WIDTH-1:0] cc_b_q, cc_b_d;
    logic [1:0]       cc_mode_q, cc_mode_d;
    logic             res_valid_q, res_valid_d;
    logic [1:0]       res_mode_q, res_mode_d;
    logic [WIDTH-1:0] res_conva_q, res_conva_d;
    logic [WIDTH-1:0] res_convb_q, res_convb_d;
    logic [2:0]       res_flags_q, res_flags_d;
    logic             res_last_q, res_last_d;

    logic [3:0] req_mask_eff;
    logic [3:0] mask_rest;
    logic [2:0] flags_in;
    logic       capture;
    logic       accept;

    function automatic logic [1:0] lowest_mode(input logic [3:0] m);
        logic [1:0] r;
        if (m[0])      r = 2'd0;
        else if (m[1]) r = 2'd1;
        else if (m[2]) r = 2'd2;
        else           r = 2'd3;
        return r;
    endfunction

    assign req_mask_eff = (req_mask == 4'd0) ? 4'b0001 : req_mask;
    // Modes still pending once the current one is done.
    assign mask_rest    = mask_q & ~(4'b0001 << cc_mode_q);
    assign flags_in     = {cc_gt, cc_lt, cc_eq};
    assign accept       = (state_q == ST_IDLE) && req_valid;
    // The counter reaches zero on this edge.
    assign capture      = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        cc_a_d      = cc_a_q;
        cc_b_d      = cc_b_q;
        cc_mode_d   = cc_mode_q;
        res_valid_d = res_valid_q;
        res_mode_d  = res_mode_q;
        res_conva_d = res_conva_q;
        res_convb_d = res_convb_q;
        res_flags_d = res_flags_q;
        res_last_d  = res_last_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    mask_d    = req_mask_eff;
                    cc_a_d    = req_a;
                    cc_b_d    = req_b;
                    cc_mode_d = lowest_mode(req_mask_eff);
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (capture) begin
                    res_mode_d  = cc_mode_q;
                    res_conva_d = cc_conva;
                    res_convb_d = cc_convb;
                    res_flags_d = flags_in;
                    res_last_d  = (mask_rest == 4'd0);
                    res_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (mask_rest != 4'd0) begin
                        mask_d    = mask_rest;
                        cc_mode_d = lowest_mode(mask_rest);
                        cnt_d     = CNT_LOAD;
                        state_d   = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            cnt_q       <= '0;
            cc_a_q      <= '0;
            cc_b_q      <= '0;
            cc_mode_q   <= '0;
            res_valid_q <= 1'b0;
            res_mode_q  <= '0;
            res_conva_q <= '0;
            res_convb_q <= '0;
            res_flags_q <= '0;
            res_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            cc_a_q      <= cc_a_d;
            cc_b_q      <= cc_b_d;
            cc_mode_q   <= cc_mode_d;
            res_valid_q <= res_valid_d;
            res_mode_q  <= res_mode_d;
            res_conva_q <= res_conva_d;
            res_convb_q <= res_convb_d;
            res_flags_q <= res_flags_d;
            res_last_q  <= res_last_d;
        end
    end

`ifdef CMP_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (capture && !(flags_in == 3'b100 || flags_in == 3'b010 ||
                                  flags_in == 3'b001)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign cc_a      = cc_a_q;
    assign cc_b      = cc_b_q;
    assign cc_mode   = cc_mode_q;
    assign res_valid = res_valid_q;
    assign res_mode  = res_mode_q;
    assign res_conva = res_conva_q;
    assign res_convb = res_convb_q;
    assign res_flags = res_flags_q;
    assign res_last  = res_last_q;

endmodule

// File: tb/tb_code_cmp_sequencer.sv
// Testbench for code_cmp_sequencer. Two instances (SETTLE=1 and SETTLE=3)
// sit beside a behavioural converter/comparator model; sel chooses which
// instance receives requests and is observed.
module tb_code_cmp_sequencer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         sel = 1'b0;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [3:0]   req_mask = '0;
  logic         res_ready = 1'b0;
  logic         force_bad = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // beat = {mode[1:0], conva[3:0], convb[3:0], flags[2:0], last}
  logic [13:0] exp_q[$];

  // ---------------- converter/comparator model (external block) ----------
  function automatic logic [W-1:0] conv(input logic [W-1:0] x, input logic [1:0] m);
    logic [W-1:0] r;
    int v;
    v = int'(x);
    case (m)
      2'd0: r = x;
      2'd1: r = x ^ (x >> 1);
      2'd2: r = W'(v + 3);
      default: r = W'(v % 10);
    endcase
    return r;
  endfunction

  function automatic logic [2:0] cmp3(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a > b, a < b, a == b};
  endfunction

  // ---------------- instance 0: SETTLE=1 ----------------
  logic         i0_req_ready, i0_res_valid, i0_res_last, i0_busy, i0_err;
  logic [W-1:0] i0_cc_a, i0_cc_b, i0_res_conva, i0_res_convb;
  logic [1:0]   i0_cc_mode, i0_res_mode;
  logic [2:0]   i0_res_flags, i0_flags;
  logic [W-1:0] i0_conva, i0_convb;

  assign i0_conva = conv(i0_cc_a, i0_cc_mode);
  assign i0_convb = conv(i0_cc_b, i0_cc_mode);
  assign i0_flags = force_bad ? 3'b101 : cmp3(i0_cc_a, i0_cc_b);

  code_cmp_sequencer #(.WIDTH(W), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(i0_req_ready),
    .req_a(req_a), .req_b(req_b), .req_mask(req_mask),
    .cc_a(i0_cc_a), .cc_b(i0_cc_b), .cc_mode(i0_cc_mode),
    .cc_gt(i0_flags[2]), .cc_lt(i0_flags[1]), .cc_eq(i0_flags[0]),
    .cc_conva(i0_conva), .cc_convb(i0_convb),
    .res_valid(i0_res_valid), .res_ready(res_ready & ~sel),
    .res_mode(i0_res_mode), .res_conva(i0_res_conva), .res_convb(i0_res_convb),
    .res_flags(i0_res_flags), .res_last(i0_res_last),
    .busy(i0_busy), .err(i0_err)
  );

  // ---------------- instance 1: SETTLE=3 ----------------
  logic         i1_req_ready, i1_res_valid, i1_res_last, i1_busy, i1_err;
  logic [W-1:0] i1_cc_a, i1_cc_b, i1_res_conva, i1_res_convb;
  logic [1:0]   i1_cc_mode, i1_res_mode;
  logic [2:0]   i1_res_flags, i1_flags;
  logic [W-1:0] i1_conva, i1_convb;

  assign i1_conva = conv(i1_cc_a, i1_cc_mode);
  assign i1_convb = conv(i1_cc_b, i1_cc_mode);
  assign i1_flags = force_bad ? 3'b101 : cmp3(i1_cc_a, i1_cc_b);

  code_cmp_sequencer #(.WIDTH(W), .SETTLE(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(i1_req_ready),
    .req_a(req_a), .req_b(req_b), .req_mask(req_mask),
    .cc_a(i1_cc_a), .cc_b(i1_cc_b), .cc_mode(i1_cc_mode),
    .cc_gt(i1_flags[2]), .cc_lt(i1_flags[1]), .cc_eq(i1_flags[0]),
    .cc_conva(i1_conva), .cc_convb(i1_convb),
    .res_valid(i1_res_valid), .res_ready(res_ready & sel),
    .res_mode(i1_res_mode), .res_conva(i1_res_conva), .res_convb(i1_res_convb),
    .res_flags(i1_res_flags), .res_last(i1_res_last),
    .busy(i1_busy), .err(i1_err)
  );

  // ---------------- observed (selected) instance ----------------
  logic         o_req_ready, o_res_valid, o_busy, o_err;
  logic [W-1:0] o_cc_a, o_cc_b;
  logic [1:0]   o_cc_mode;
  logic [13:0]  o_beat;
  int           settle_sel;

  always_comb begin
    o_req_ready = sel ? i1_req_ready : i0_req_ready;
    o_res_valid = sel ? i1_res_valid : i0_res_valid;
    o_busy      = sel ? i1_busy      : i0_busy;
    o_err       = sel ? i1_err       : i0_err;
    o_cc_a      = sel ? i1_cc_a      : i0_cc_a;
    o_cc_b      = sel ? i1_cc_b      : i0_cc_b;
    o_cc_mode   = sel ? i1_cc_mode   : i0_cc_mode;
    o_beat      = sel ? {i1_res_mode, i1_res_conva, i1_res_convb, i1_res_flags, i1_res_last}
                      : {i0_res_mode, i0_res_conva, i0_res_convb, i0_res_flags, i0_res_last};
    settle_sel  = sel ? 3 : 1;
  end

  // ---------------- tasks ----------------
  task automatic recover();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    res_ready = 1'b0;
    exp_q.delete();
  endtask

  // Issue one request, then consume and check every beat.
  task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] m, input int stall,
                         input logic noise, input logic bad);
    logic [3:0]  eff;
    logic [13:0] exp_b;
    logic [2:0]  fl;
    int          nb;
    int          left;
    int          w;
    eff = (m == 4'd0) ? 4'b0001 : m;
    nb = $countones(eff);
    fl = bad ? 3'b101 : cmp3(a, b);
    force_bad = bad;
    left = nb;
    for (int i = 0; i < 4; i++) begin
      if (eff[i]) begin
        left--;
        exp_q.push_back({2'(i), conv(a, 2'(i)), conv(b, 2'(i)), fl, (left == 0)});
      end
    end

    req_a = a; req_b = b; req_mask = m; req_valid = 1'b1;
    n_cmp++;
    if (o_req_ready !== 1'b1) begin
      $display("FAIL req_ready_idle: got %b want 1", o_req_ready); n_err++;
    end
    @(negedge clk);

    for (int k = 0; k < nb; k++) begin
      exp_b = exp_q.pop_front();
      if (noise) begin
        req_valid = 1'b1;
        req_a = W'($urandom_range(0, 15));
        req_b = W'($urandom_range(0, 15));
        req_mask = 4'($urandom_range(0, 15));
      end else begin
        req_valid = 1'b0;
      end
      w = 0;
      while (o_res_valid !== 1'b1 && w <= 20) begin
        @(negedge clk);
        w++;
      end
      if (w > 20) begin
        $display("FAIL beat_timeout: beat %0d never became valid", k);
        n_cmp++; n_err++;
        recover();
        return;
      end
      n_cmp++;
      if (w != settle_sel) begin
        $display("FAIL beat_latency: got %0d edges want %0d", w, settle_sel); n_err++;
      end
      n_cmp++;
      if (o_beat !== exp_b) begin
        $display("FAIL beat_data: got %h want %h (a=%h b=%h mask=%b beat %0d)",
                 o_beat, exp_b, a, b, m, k); n_err++;
      end
      n_cmp++;
      if (o_cc_a !== a || o_cc_b !== b || o_cc_mode !== exp_b[13:12]) begin
        $display("FAIL cc_drive: got a=%h b=%h mode=%h want a=%h b=%h mode=%h",
                 o_cc_a, o_cc_b, o_cc_mode, a, b, exp_b[13:12]); n_err++;
      end
      n_cmp++;
      if (o_req_ready !== 1'b0 || o_busy !== 1'b1) begin
        $display("FAIL busy_ready: got ready=%b busy=%b want 0/1", o_req_ready, o_busy);
        n_err++;
      end
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        n_cmp++;
        if (o_res_valid !== 1'b1 || o_beat !== exp_b || o_cc_mode !== exp_b[13:12]) begin
          $display("FAIL stall_hold: got v=%b beat=%h mode=%h want 1/%h/%h",
                   o_res_valid, o_beat, o_cc_mode, exp_b, exp_b[13:12]); n_err++;
        end
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      if (k == nb - 1) begin
        req_valid = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b0 || o_req_ready !== 1'b1 || o_res_valid !== 1'b0) begin
          $display("FAIL done_idle: got busy=%b ready=%b valid=%b want 0/1/0",
                   o_busy, o_req_ready, o_res_valid); n_err++;
        end
      end
    end
    force_bad = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (o_res_valid !== 1'b0 || o_busy !== 1'b0) begin
      $display("FAIL extra_beat: got valid=%b busy=%b want 0/0", o_res_valid, o_busy);
      n_err++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({i0_res_valid, i0_busy, i0_err, i0_cc_a, i0_cc_b, i0_cc_mode, i0_res_mode,
         i0_res_conva, i0_res_convb, i0_res_flags, i0_res_last} !== '0 ||
        {i1_res_valid, i1_busy, i1_err, i1_cc_a, i1_cc_b, i1_cc_mode, i1_res_mode,
         i1_res_conva, i1_res_convb, i1_res_flags, i1_res_last} !== '0) begin
      $display("FAIL reset_outputs: outputs not all zero (i0 beat=%h i1 beat=%h)",
               {i0_res_mode, i0_res_conva, i0_res_convb, i0_res_flags, i0_res_last},
               {i1_res_mode, i1_res_conva, i1_res_convb, i1_res_flags, i1_res_last});
      n_err++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    sel = 1'b0;
    run_req(4'd6, 4'd3, 4'b0001, 0, 1'b0, 1'b0);
  endtask

  task automatic test_all_modes();
    sel = 1'b0;
    run_req(4'd9, 4'd4, 4'b1111, 0, 1'b0, 1'b0);
  endtask

  task automatic test_excess3_and_zero_mask();
    sel = 1'b0;
    run_req(4'd2, 4'd6, 4'b0100, 0, 1'b0, 1'b0);
    run_req(4'd5, 4'd7, 4'b0000, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    run_req(4'd5, 4'd1, 4'b0011, 5, 1'b0, 1'b0);
  endtask

  task automatic test_settle3();
    sel = 1'b1;
    run_req(4'd9, 4'd4, 4'b1111, 0, 1'b0, 1'b0);
    run_req(4'd3, 4'd12, 4'b1010, 2, 1'b0, 1'b0);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_req(4'd7, 4'd7, 4'b0110, 0, 1'b1, 1'b0);
    run_req(4'd1, 4'd14, 4'b1001, 1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int w;
    sel = 1'b0;
    req_a = 4'd9; req_b = 4'd4; req_mask = 4'b1111; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (o_res_valid !== 1'b1 && w <= 20) begin
      @(negedge clk);
      w++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    // Controller now waits on the second beat.
    rst = 1'b1;
    #1;
    n_cmp++;
    if (o_res_valid !== 1'b0 || o_busy !== 1'b0 || o_cc_a !== '0 || o_cc_b !== '0 ||
        o_cc_mode !== 2'd0) begin
      $display("FAIL reset_mid: got valid=%b busy=%b cc_a=%h cc_b=%h mode=%h want all 0",
               o_res_valid, o_busy, o_cc_a, o_cc_b, o_cc_mode); n_err++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_res_valid !== 1'b0) begin
      $display("FAIL reset_no_beat: got valid=%b want 0", o_res_valid); n_err++;
    end
    run_req(4'd9, 4'd4, 4'b1111, 0, 1'b0, 1'b0);
  endtask

  task automatic test_cmp_check();
    sel = 1'b0;
    run_req(4'd3, 4'd3, 4'b0011, 0, 1'b0, 1'b1);
    n_cmp++;
`ifdef CMP_CHECK_EN
    if (o_err !== 1'b1) begin
      $display("FAIL err_set: got %b want 1", o_err); n_err++;
    end
`else
    if (o_err !== 1'b0) begin
      $display("FAIL err_tied: got %b want 0", o_err); n_err++;
    end
`endif
    run_req(4'd3, 4'd3, 4'b0001, 0, 1'b0, 1'b0);
    n_cmp++;
    if (o_err !== 1'b0) begin
      $display("FAIL err_clear: got %b want 0", o_err); n_err++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      run_req(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b0);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_modes();
    test_excess3_and_zero_mask();
    test_backpressure();
    test_settle3();
    test_back_to_back();
    test_reset_mid();
    test_cmp_check();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
